// File: rtl/hu_bus_arbiter.sv
// hu_bus_arbiter: shares the single-port system memory between the 65C02 bus and a DMA requester.
// Define ARB_WAITSTATE_EN to add a one-cycle WAIT state for CPU accesses to the slow region.
module hu_bus_arbiter #(
    parameter int unsigned MAX_BURST  = 8,
    parameter logic [15:0] SLOW_MASK  = 16'hFC00,
    parameter logic [15:0] SLOW_MATCH = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        RDY,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_we,
    output logic        dma_gnt,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic        mem_we
);

`ifdef ARB_WAITSTATE_EN
    localparam bit WaitEn = 1'b1;
`else
    localparam bit WaitEn = 1'b0;
`endif

    localparam logic [7:0] BurstMax = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_CPU,
        ST_DMA,
        ST_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       rdy_q, rdy_d;
    logic       was_cpu_q, was_cpu_d;
    logic       was_wait_q, was_wait_d;
    logic [7:0] hold_q, hold_d;
    logic       rvalid_q, rvalid_d;
    logic [7:0] rdata_q, rdata_d;

    logic       in_cpu;
    logic       in_dma;
    logic       slow_hit;
    logic       first_stall;
    logic [7:0] count_inc;

    always_comb begin
        in_cpu      = (state_q == ST_CPU);
        in_dma      = (state_q == ST_DMA);
        slow_hit    = WaitEn && ((AB & SLOW_MASK) == SLOW_MATCH);
        first_stall = !in_cpu && was_cpu_q;
        count_inc   = count_q + 8'd1;

        dma_gnt  = in_dma && dma_req;
        mem_addr = in_dma ? dma_addr : AB;
        mem_din  = in_dma ? dma_wdata : DO;
        mem_we   = 1'b0;
        if (in_cpu) begin
            mem_we = WE;
        end else if (in_dma) begin
            mem_we = dma_we & dma_req;
        end

        // The CPU's last read lands on mem_dout in the first stalled cycle.
        DI         = (in_cpu || first_stall) ? mem_dout : hold_q;
        RDY        = rdy_q;
        dma_rvalid = rvalid_q;
        dma_rdata  = rvalid_q ? mem_dout : rdata_q;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            ST_CPU: begin
                // Re-issued slow address after WAIT must not loop back.
                if (slow_hit && !was_wait_q) begin
                    state_d = ST_WAIT;
                end else if (dma_req && !WE) begin
                    state_d = ST_DMA;
                end
            end
            ST_DMA: begin
                if (!dma_req || count_inc == BurstMax) begin
                    state_d = ST_CPU;
                    count_d = '0;
                end else begin
                    count_d = count_inc;
                end
            end
            ST_WAIT: begin
                state_d = ST_CPU;
            end
            default: begin
                state_d = ST_CPU;
                count_d = '0;
            end
        endcase

        rdy_d      = (state_d == ST_CPU);
        was_cpu_d  = in_cpu;
        was_wait_d = (state_q == ST_WAIT);
        hold_d     = first_stall ? mem_dout : hold_q;
        rvalid_d   = dma_gnt && !dma_we;
        rdata_d    = rvalid_q ? mem_dout : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CPU;
            count_q    <= '0;
            rdy_q      <= 1'b1;
            was_cpu_q  <= 1'b1;
            was_wait_q <= 1'b0;
            hold_q     <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rdy_q      <= rdy_d;
            was_cpu_q  <= was_cpu_d;
            was_wait_q <= was_wait_d;
            hold_q     <= hold_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_hu_bus_arbiter.sv
// tb_hu_bus_arbiter: directed and random stimulus for hu_bus_arbiter,
// checked against a cycle-level ownership model with its own memory image.
module tb_hu_bus_arbiter;

    localparam int MAXB = 8;
`ifdef ARB_WAITSTATE_EN
    localparam bit WS = 1'b1;
`else
    localparam bit WS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DI;
    logic        RDY;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_we;
    logic        dma_gnt;
    logic [7:0]  dma_rdata;
    logic        dma_rvalid;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        mem_we;

    always #5 clk = ~clk;

    hu_bus_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .AB(AB), .DO(DO), .WE(WE), .DI(DI), .RDY(RDY),
        .dma_req(dma_req), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_we(mem_we)
    );

    // Synchronous-read memory, filled with a known pattern on the first edge.
    logic [7:0] mem [0:65535];
    bit         mem_ready;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'(i * 7 + 3);
            mem_dout  <= 8'h00;
            mem_ready <= 1'b1;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_din;
            mem_dout <= mem[mem_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int gnt_cnt  = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the bus, how long it has owned it, and memory.
    logic [7:0] ref_mem [0:65535];
    bit         m_dma, m_wait, m_first, m_after, m_rv;
    int         m_cnt;
    logic [7:0] m_dout, m_hold;

    function automatic bit is_slow(logic [15:0] a);
        return a < 16'h0400;
    endfunction

    task automatic drive(bit rst, logic [15:0] ab, logic [7:0] cd, bit we,
                         bit req, logic [15:0] da, logic [7:0] dwd, bit dwe);
        reset     = rst;
        AB        = ab;
        DO        = cd;
        WE        = we;
        dma_req   = req;
        dma_addr  = da;
        dma_wdata = dwd;
        dma_we    = dwe;
    endtask

    task automatic cycle();
        bit          cpu_now, gnt_e, we_e, n_dma, n_wait;
        int          n_cnt;
        logic [15:0] addr_e;
        logic [7:0]  din_e, di_e, nxt_dout;
        #1;
        cpu_now = !m_dma && !m_wait;
        gnt_e   = m_dma && dma_req;
        addr_e  = m_dma ? dma_addr : AB;
        din_e   = m_dma ? dma_wdata : DO;
        we_e    = m_dma ? (dma_req && dma_we) : (cpu_now && WE);
        di_e    = (cpu_now || m_first) ? m_dout : m_hold;
        check_eq("rdy", 32'(RDY), 32'(cpu_now));
        check_eq("gnt", 32'(dma_gnt), 32'(gnt_e));
        check_eq("mem_addr", 32'(mem_addr), 32'(addr_e));
        check_eq("mem_we", 32'(mem_we), 32'(we_e));
        if (we_e) check_eq("mem_din", 32'(mem_din), 32'(din_e));
        check_eq("di", 32'(DI), 32'(di_e));
        check_eq("rvalid", 32'(dma_rvalid), 32'(m_rv));
        if (m_rv) check_eq("rdata", 32'(dma_rdata), 32'(m_dout));
        if (dma_gnt) gnt_cnt++;
        @(posedge clk);
        nxt_dout = ref_mem[addr_e];
        if (we_e) ref_mem[addr_e] = din_e;
        n_dma  = m_dma;
        n_wait = 1'b0;
        n_cnt  = m_cnt;
        if (m_dma) begin
            if (gnt_e) n_cnt = m_cnt + 1;
            if (!dma_req || n_cnt == MAXB) begin
                n_dma = 1'b0;
                n_cnt = 0;
            end
        end else if (cpu_now) begin
            if (WS && is_slow(AB) && !m_after) n_wait = 1'b1;
            else if (dma_req && !WE) n_dma = 1'b1;
        end
        if (reset) begin
            m_dma   = 1'b0;
            m_wait  = 1'b0;
            m_cnt   = 0;
            m_first = 1'b0;
            m_after = 1'b0;
            m_rv    = 1'b0;
            m_hold  = 8'h00;
        end else begin
            if (m_first) m_hold = m_dout;
            m_first = cpu_now && (n_dma || n_wait);
            m_rv    = gnt_e && !dma_we;
            m_after = m_wait;
            m_dma   = n_dma;
            m_wait  = n_wait;
            m_cnt   = n_cnt;
        end
        m_dout = nxt_dout;
        @(negedge clk);
    endtask

    initial begin
        bit          r_req;
        logic [15:0] r_ab;
        int          sel;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 7 + 3);
        m_dout = 8'h00;
        m_hold = 8'h00;
        drive(1, 16'h2000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        repeat (2) cycle();

        // Reset in the middle of a DMA read burst.
        drive(0, 16'h2000, 0, 0, 1, 16'h2001, 0, 0);
        repeat (4) cycle();
        drive(1, 16'h2000, 0, 0, 1, 16'h2001, 0, 0);
        repeat (2) cycle();
        drive(0, 16'h2002, 0, 0, 1, 16'h2001, 0, 0);
        #1;
        check_eq("rst_rdy", 32'(RDY), 1);
        check_eq("rst_gnt", 32'(dma_gnt), 0);
        check_eq("rst_rvalid", 32'(dma_rvalid), 0);
        check_eq("rst_addr", 32'(mem_addr), 32'h2002);
        cycle();
        drive(0, 16'h2002, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();

        // CPU hold across a stall, DMA write then read-back.
        drive(0, 16'h1234, 8'h5A, 1, 0, 0, 0, 0);
        cycle();
        drive(0, 16'h1234, 0, 0, 1, 16'h2000, 8'hA5, 1);
        cycle();
        #1;
        check_eq("hold_rdy", 32'(RDY), 0);
        check_eq("hold_di0", 32'(DI), 32'h5A);
        check_eq("dwr_we", 32'(mem_we), 1);
        cycle();
        drive(0, 16'h1234, 0, 0, 1, 16'h2000, 0, 0);
        #1;
        check_eq("hold_di1", 32'(DI), 32'h5A);
        check_eq("drd_we", 32'(mem_we), 0);
        cycle();
        drive(0, 16'h1234, 0, 0, 1, 16'h2005, 0, 0);
        #1;
        check_eq("rd_valid", 32'(dma_rvalid), 1);
        check_eq("rd_data", 32'(dma_rdata), 32'hA5);
        check_eq("hold_di2", 32'(DI), 32'h5A);
        cycle();
        drive(0, 16'h1234, 0, 0, 0, 0, 0, 0);
        cycle();
        #1;
        check_eq("back_rdy", 32'(RDY), 1);
        cycle();

        // Continuous requester: 8 granted, 1 CPU cycle, repeating.
        gnt_cnt = 0;
        drive(0, 16'h2003, 0, 0, 1, 16'h2004, 0, 0);
        repeat (20) cycle();
        check_eq("burst_gnts", 32'(gnt_cnt), 17);
        drive(0, 16'h2003, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();

        // DMA request during a CPU write waits for the next read.
        drive(0, 16'h3000, 8'h77, 1, 1, 16'h2000, 0, 0);
        #1;
        check_eq("wr_nognt", 32'(dma_gnt), 0);
        check_eq("wr_we", 32'(mem_we), 1);
        cycle();
        drive(0, 16'h3001, 0, 0, 1, 16'h3000, 0, 0);
        #1;
        check_eq("wr_rdy", 32'(RDY), 1);
        cycle();
        #1;
        check_eq("wr_gnt", 32'(dma_gnt), 1);
        cycle();
        drive(0, 16'h3001, 0, 0, 0, 0, 0, 0);
        #1;
        check_eq("wr_rdata", 32'(dma_rdata), 32'h77);
        cycle();
        cycle();

`ifdef ARB_WAITSTATE_EN
        // Slow read takes one wait cycle and defers the DMA request.
        drive(0, 16'h0010, 0, 0, 1, 16'h2000, 0, 0);
        cycle();
        #1;
        check_eq("ws_rdy", 32'(RDY), 0);
        check_eq("ws_gnt", 32'(dma_gnt), 0);
        check_eq("ws_di", 32'(DI), 32'h73);
        cycle();
        #1;
        check_eq("ws_back", 32'(RDY), 1);
        check_eq("ws_defer", 32'(dma_gnt), 0);
        cycle();
        #1;
        check_eq("ws_gnt2", 32'(dma_gnt), 1);
        cycle();
        drive(0, 16'h2000, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();
`endif

        // Random traffic against the model.
        r_req = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) r_req = !r_req;
            sel = int'($urandom_range(0, 3));
            if (sel < 2) r_ab = 16'h2000 | 16'($urandom_range(0, 15));
            else if (sel == 2) r_ab = 16'($urandom_range(0, 15));
            else r_ab = 16'($urandom);
            drive($urandom_range(0, 299) == 0, r_ab, 8'($urandom),
                  $urandom_range(0, 3) == 0, r_req,
                  16'h2000 | 16'($urandom_range(0, 15)), 8'($urandom),
                  $urandom_range(0, 2) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
